sync_fifo_ram: RTL and testbench

SYNC_FIFO_RAM -- requirements
Module: sync_fifo_ram

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 39 +++
 rtl/sync_fifo_ram.sv | 166 ++++++++++++++++
 tb/tb_sync_fifo_ram.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous RAM-backed FIFO.
package sync_fifo_pkg;

  localparam int DEF_AEMPTY_THRESH = 4;
  localparam int DEF_AFULL_MARGIN  = 4;

  // Pointers carry one extra wrap bit so full and empty differ without a spare slot.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module fifo_mem #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Write port; the array has no reset so it stays mappable to block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register only updates on a read, so the last word is held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO over fifo_mem with registered level/status flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is standard read mode.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 36,
  parameter int ADDR_WIDTH    = 9,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] ONE_L    = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         level_r;
  logic [PW-1:0]         level_next_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  afull_r;
  logic                  aempty_r;
  logic                  ovf_r;
  logic                  udf_r;
  logic                  rd_valid_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  mem_rd_s;
  logic [DATA_WIDTH-1:0] mem_q_s;

  assign wr_acc_s = wr_en & ~full_r;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_acc_s & ~reset),
    .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (mem_rd_s & ~reset),
    .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
    .rd_data (mem_q_s)
  );

  // Occupancy after this edge's accepted push/pop.
  always_comb begin
    level_next_s = level_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_next_s = level_r + ONE_L;
      2'b01:   level_next_s = level_r - ONE_L;
      default: level_next_s = level_r;
    endcase
  end

  // Write pointer, level, status flags and error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_L;
      end
      level_r  <= level_next_s;
      full_r   <= (level_next_s == DEPTH_L);
      empty_r  <= (level_next_s == '0);
      afull_r  <= (level_next_s >= AFULL_L);
      aempty_r <= (level_next_s <= AEMPTY_L);
      ovf_r    <= wr_en & full_r;
      udf_r    <= rd_en & ~rd_acc_s;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Two-stage prefetch: RAM output register (s1) feeds the presented head word.
  logic                  s1_valid_r;
  logic                  s1_take_s;
  logic [PW-1:0]         ram_cnt_s;
  logic [DATA_WIDTH-1:0] rd_data_r;

  assign rd_acc_s  = rd_en & rd_valid_r;
  assign ram_cnt_s = wr_ptr_r - rd_ptr_r;
  assign s1_take_s = s1_valid_r & (~rd_valid_r | rd_acc_s);
  assign mem_rd_s  = (ram_cnt_s != '0) & (~s1_valid_r | s1_take_s);

  // Prefetch pipeline and head-word register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r   <= '0;
      s1_valid_r <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      if (mem_rd_s) begin
        rd_ptr_r   <= rd_ptr_r + ONE_L;
        s1_valid_r <= 1'b1;
      end else if (s1_take_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s1_take_s) begin
        rd_data_r  <= mem_q_s;
        rd_valid_r <= 1'b1;
      end else if (rd_acc_s) begin
        rd_valid_r <= 1'b0;
      end
    end
  end

  assign rd_data = rd_data_r;
`else
  assign rd_acc_s = rd_en & ~empty_r;
  assign mem_rd_s = rd_acc_s;

  // Read pointer; rd_valid marks the single cycle after an accepted pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r   <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_L;
      end
      rd_valid_r <= rd_acc_s;
    end
  end

  assign rd_data = mem_q_s;
`endif

  assign rd_valid     = rd_valid_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign level        = level_r;
  assign overflow     = ovf_r;
  assign underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed self-checking bench for sync_fifo_ram (8-bit x 16, thresholds 12/4).
module tb_sync_fifo_ram;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  sync_fifo_ram #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    reset = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      chk("fill_level", level, i + 1);
      chk("fill_afull", almost_full, (i + 1 >= 12));
      chk("fill_full", full, (i + 1 == 16));
      chk("fill_aempty", almost_empty, (i + 1 <= 4));
      chk("fill_empty", empty, 0);
    end
    wr_data = 8'hEE;
    tick();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_level", level, 16);
    wr_en = 1'b0;
    tick();
    chk("ovf_clear", overflow, 0);
    chk("ovf_level_hold", level, 16);

`ifndef SYNC_FIFO_FWFT_EN
    // Drain all 16 in order
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      chk("drain_level", level, 15 - i);
    end
    chk("drain_empty", empty, 1);
    tick();
    chk("udf_pulse", underflow, 1);
    chk("udf_valid", rd_valid, 0);
    chk("udf_level", level, 0);
    chk("udf_data_hold", rd_data, 8'h0F);
    rd_en = 1'b0;
    tick();
    chk("udf_clear", underflow, 0);

    // Fill to 8, then 40 cycles of simultaneous push/pop across pointer wraps
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h40 + i);
      exp_q.push_back(wr_data);
      tick();
    end
    chk("stream_fill_level", level, 8);
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(32'h48 + k);
      tick();
      exp_d = exp_q.pop_front();
      exp_q.push_back(wr_data);
      chk("stream_level", level, 8);
      chk("stream_valid", rd_valid, 1);
      chk("stream_data", rd_data, exp_d);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      exp_d = exp_q.pop_front();
      chk("stream_tail_data", rd_data, exp_d);
    end
    rd_en = 1'b0;
    chk("stream_empty", empty, 1);
    chk("stream_tail_level", level, 0);

    // Full with concurrent push and pop: pop accepted, push rejected
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h80 + i);
      tick();
    end
    chk("full2_full", full, 1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
    tick();
    chk("fullrw_ovf", overflow, 1);
    chk("fullrw_level", level, 15);
    chk("fullrw_valid", rd_valid, 1);
    chk("fullrw_data", rd_data, 8'h80);
    chk("fullrw_full", full, 0);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    chk("fullrw_ovf_clear", overflow, 0);
    chk("fullrw_level_hold", level, 15);
`endif

    // Reset mid-operation with wr_en held high
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h10 + i);
      tick();
    end
    chk("pre_rst_level", level, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_udf", underflow, 0);
    tick();
    chk("postrst_level", level, 0);
    chk("postrst_ovf", overflow, 0);
    chk("postrst_udf", underflow, 0);

    // Single word 0xA5 into an empty FIFO
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("a5_valid_n", rd_valid, 0);
    chk("a5_level", level, 1);
`ifdef SYNC_FIFO_FWFT_EN
    tick();
    chk("a5_valid_n1", rd_valid, 0);
    tick();
    chk("a5_valid_n2", rd_valid, 1);
    chk("a5_data_n2", rd_data, 8'hA5);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("a5_pop_level", level, 0);
    chk("a5_pop_valid", rd_valid, 0);
`else
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("a5_valid", rd_valid, 1);
    chk("a5_data", rd_data, 8'hA5);
    chk("a5_pop_level", level, 0);
    tick();
    chk("a5_valid_drop", rd_valid, 0);
    chk("a5_data_hold", rd_data, 8'hA5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
